// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - I/D cache to single memory port arbiter with registered command and ack pulse
// Optional ARB_ROUND_ROBIN_EN: alternate grants on simultaneous requests instead of D-over-I priority.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_ack,
    output logic [DATA_WIDTH-1:0] i_rdata,
    input  logic                  d_req,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_ack,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  mem_req,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    state_t state;
    state_t state_next;
    logic   last_grant;
    logic   grant_d;
    logic   grant_i;

    always_comb begin
        grant_d = 1'b0;
        grant_i = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        grant_d = d_req && (!i_req || (last_grant == GRANT_I));
`else
        grant_d = d_req;
`endif
        grant_i = i_req && !grant_d;
    end

`ifndef ARB_ROUND_ROBIN_EN
    // last_grant is still tracked in fixed mode so both builds share one state set
    logic last_grant_unused;
    assign last_grant_unused = last_grant;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    state_next = BUSY_D;
                end else if (grant_i) begin
                    state_next = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ack) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_req    <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            i_ack      <= 1'b0;
            d_ack      <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
            last_grant <= GRANT_I;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        mem_req    <= 1'b1;
                        mem_write  <= d_write;
                        mem_addr   <= d_addr;
                        mem_wdata  <= d_wdata;
                        last_grant <= GRANT_D;
                    end else if (grant_i) begin
                        mem_req    <= 1'b1;
                        mem_write  <= 1'b0;
                        mem_addr   <= i_addr;
                        mem_wdata  <= '0;
                        last_grant <= GRANT_I;
                    end
                end
                BUSY_I: begin
                    if (mem_ack) begin
                        i_rdata   <= mem_rdata;
                        i_ack     <= 1'b1;
                        mem_req   <= 1'b0;
                        mem_write <= 1'b0;
                    end
                end
                BUSY_D: begin
                    if (mem_ack) begin
                        // write-backs complete with an ack but leave the last refill line intact
                        if (!mem_write) begin
                            d_rdata <= mem_rdata;
                        end
                        d_ack     <= 1'b1;
                        mem_req   <= 1'b0;
                        mem_write <= 1'b0;
                    end
                end
                RESP: begin
                    i_ack <= 1'b0;
                    d_ack <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
// Optional ARB_ROUND_ROBIN_EN selects the round-robin expected grant orders.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          i_ack;
    logic [DW-1:0] i_rdata;
    logic          d_req = 1'b0;
    logic          d_write = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic          mem_req;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    int            mem_wait = 1;
    logic          mem_tie = 1'b0;
    logic [DW-1:0] mem_line = '0;
    int            mcnt = 0;
    int            i_left = 0;
    int            d_left = 0;

    logic [7:0]    order_q[$];
    int            cyc_q[$];
    int            dbl = 0;
    int            unstable = 0;
    int            txn = 0;
    logic [AW-1:0] rec_addr = '0;
    logic          rec_write = 1'b0;
    logic [DW-1:0] rec_wdata = '0;
    logic          i_prev = 1'b0;
    logic          d_prev = 1'b0;
    logic          req_prev = 1'b0;
    logic [AW-1:0] addr_prev = '0;
    logic          write_prev = 1'b0;
    logic [DW-1:0] wdata_prev = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // memory responder plus the two requester agents, all acting just after the edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mem_tie) mem_ack = 1'b1;
            else if (mem_ack) begin mem_ack = 1'b0; mcnt = 0; end
            else if (mem_req) begin mcnt++; if (mcnt >= mem_wait) mem_ack = 1'b1; end
            else mcnt = 0;
            mem_rdata = mem_line;
            if (!reset) begin
                if (d_ack) begin
                    d_left--; d_addr = d_addr + 32'h10;
                    if (d_left <= 0) d_req = 1'b0;
                end else if (d_left > 0) d_req = 1'b1;
                if (i_ack) begin
                    i_left--; i_addr = i_addr + 32'h10;
                    if (i_left <= 0) i_req = 1'b0;
                end else if (i_left > 0) i_req = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (i_ack) begin order_q.push_back(8'h49); cyc_q.push_back(cyc); if (i_prev) dbl++; end
            if (d_ack) begin order_q.push_back(8'h44); cyc_q.push_back(cyc); if (d_prev) dbl++; end
            if (mem_req && mem_ack) begin
                rec_addr = mem_addr; rec_write = mem_write; rec_wdata = mem_wdata; txn++;
            end
            if (mem_req && req_prev &&
                (mem_addr != addr_prev || mem_write != write_prev || mem_wdata != wdata_prev))
                unstable++;
        end
        i_prev = i_ack; d_prev = d_ack; req_prev = mem_req;
        addr_prev = mem_addr; write_prev = mem_write; wdata_prev = mem_wdata;
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        i_left = 0; d_left = 0; i_req = 1'b0; d_req = 1'b0; d_write = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        order_q.delete(); cyc_q.delete();
        dbl = 0; unstable = 0; txn = 0;
        rec_addr = '0; rec_write = 1'b0; rec_wdata = '0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while ((i_left > 0 || d_left > 0 || mem_req) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            total++; bad++;
            $display("FAIL %s_timeout waited=%0d cycles want=idle", name, n);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; i_req = 1'b1; d_req = 1'b1; mem_tie = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({mem_req, mem_write, i_ack, d_ack} !== 4'b0000) begin
            bad++; $display("FAIL reset_ctrl got=%b want=0000", {mem_req, mem_write, i_ack, d_ack});
        end
        total++;
        if (mem_addr !== '0 || mem_wdata !== '0) begin
            bad++; $display("FAIL reset_cmd got addr=%h wdata=%h want=0", mem_addr, mem_wdata);
        end
        total++;
        if (i_rdata !== '0 || d_rdata !== '0) begin
            bad++; $display("FAIL reset_rdata got i=%h d=%h want=0", i_rdata, d_rdata);
        end
        mem_tie = 1'b0;
        do_reset();
    endtask

    task automatic test_i_read();
        int start;
        do_reset();
        mem_wait = 3; mem_line = {16{8'hA5}};
        @(negedge clk);
        i_addr = 32'h40; i_left = 1; start = cyc + 1;
        wait_idle(50, "i_read");
        total++;
        if (order_q.size() !== 1) begin
            bad++; $display("FAIL i_read_ack_count got=%0d want=1", order_q.size());
        end else begin
            total++;
            if (order_q[0] !== 8'h49) begin bad++; $display("FAIL i_read_side got=%c want=I", order_q[0]); end
            total++;
            if (cyc_q[0] - start !== 4) begin
                bad++; $display("FAIL i_read_latency got=%0d want=4", cyc_q[0] - start);
            end
        end
        total++;
        if (i_rdata !== {16{8'hA5}}) begin bad++; $display("FAIL i_read_rdata got=%h want=a5..", i_rdata); end
        total++;
        if (rec_addr !== 32'h40 || rec_write !== 1'b0) begin
            bad++; $display("FAIL i_read_cmd got addr=%h wr=%b want 40/0", rec_addr, rec_write);
        end
        total++;
        if (dbl !== 0 || unstable !== 0) begin
            bad++; $display("FAIL i_read_pulse got dbl=%0d unstable=%0d want 0/0", dbl, unstable);
        end
    endtask

    task automatic test_d_writeback();
        do_reset();
        mem_wait = 2; mem_line = {16{8'h3C}};
        @(negedge clk);
        d_write = 1'b0; d_addr = 32'h80; d_left = 1;
        wait_idle(50, "d_refill");
        total++;
        if (d_rdata !== {16{8'h3C}} || rec_write !== 1'b0) begin
            bad++; $display("FAIL d_refill got rdata=%h wr=%b want 3c../0", d_rdata, rec_write);
        end
        mem_line = {16{8'hEE}};
        @(negedge clk);
        d_write = 1'b1; d_addr = 32'h100; d_wdata = 128'h1234; d_left = 1;
        wait_idle(50, "d_write");
        total++;
        if (rec_write !== 1'b1 || rec_addr !== 32'h100 || rec_wdata !== 128'h1234) begin
            bad++; $display("FAIL d_write_cmd got wr=%b addr=%h wdata=%h want 1/100/1234",
                            rec_write, rec_addr, rec_wdata);
        end
        total++;
        if (d_rdata !== {16{8'h3C}}) begin
            bad++; $display("FAIL d_write_rdata_kept got=%h want=3c..", d_rdata);
        end
        total++;
        if (order_q.size() !== 2 || txn !== 2 || dbl !== 0 || unstable !== 0) begin
            bad++; $display("FAIL d_write_acks got acks=%0d txn=%0d dbl=%0d unst=%0d want 2/2/0/0",
                            order_q.size(), txn, dbl, unstable);
        end
        d_write = 1'b0;
    endtask

    task automatic test_tie();
        string exp;
`ifdef ARB_ROUND_ROBIN_EN
        exp = "DID";
`else
        exp = "DDI";
`endif
        do_reset();
        mem_wait = 1; mem_line = {16{8'h5C}};
        @(negedge clk);
        d_addr = 32'h500; i_addr = 32'h600; d_left = 2; i_left = 1;
        wait_idle(80, "tie");
        total++;
        if (order_q.size() !== exp.len()) begin
            bad++; $display("FAIL tie_count got=%0d want=%0d", order_q.size(), exp.len());
        end else begin
            for (int k = 0; k < exp.len(); k++) begin
                total++;
                if (order_q[k] !== exp[k]) begin
                    bad++; $display("FAIL tie_order[%0d] got=%c want=%c", k, order_q[k], exp[k]);
                end
            end
            total++;
            if (cyc_q[1] - cyc_q[0] !== 3) begin
                bad++; $display("FAIL tie_gap got=%0d want=3", cyc_q[1] - cyc_q[0]);
            end
        end
        total++;
        if (i_rdata !== {16{8'h5C}}) begin bad++; $display("FAIL tie_i_rdata got=%h want=5c..", i_rdata); end
    endtask

    task automatic test_zero_wait();
        int start;
        int busy_seen = 0;
        do_reset();
        mem_tie = 1'b1; mem_line = {16{8'h81}};
        repeat (6) begin
            @(negedge clk);
            if (mem_req || i_ack || d_ack) busy_seen++;
        end
        total++;
        if (busy_seen !== 0) begin bad++; $display("FAIL idle_mem_ack got=%0d busy cycles want=0", busy_seen); end
        i_addr = 32'h700; i_left = 1; start = cyc + 1;
        wait_idle(50, "zw_i");
        total++;
        if (cyc_q.size() !== 1) begin
            bad++; $display("FAIL zw_i_count got=%0d want=1", cyc_q.size());
        end else begin
            total++;
            if (cyc_q[0] - start !== 2) begin bad++; $display("FAIL zw_i_latency got=%0d want=2", cyc_q[0] - start); end
        end
        mem_line = {16{8'h92}};
        @(negedge clk);
        d_addr = 32'h800; d_left = 1; start = cyc + 1;
        wait_idle(50, "zw_d");
        total++;
        if (cyc_q.size() !== 2) begin
            bad++; $display("FAIL zw_d_count got=%0d want=2", cyc_q.size());
        end else begin
            total++;
            if (cyc_q[1] - start !== 2) begin bad++; $display("FAIL zw_d_latency got=%0d want=2", cyc_q[1] - start); end
        end
        total++;
        if (d_rdata !== {16{8'h92}} || dbl !== 0) begin
            bad++; $display("FAIL zw_d_rdata got=%h dbl=%0d want=92../0", d_rdata, dbl);
        end
        mem_tie = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        int busy_seen = 0;
        do_reset();
        mem_wait = 6; mem_line = {16{8'h66}};
        @(negedge clk);
        d_addr = 32'h200; d_left = 1;
        repeat (3) @(negedge clk);
        total++;
        if (mem_req !== 1'b1) begin bad++; $display("FAIL mid_busy got mem_req=%b want=1", mem_req); end
        reset = 1'b1; d_left = 0; d_req = 1'b0;
        @(negedge clk);
        total++;
        if (mem_req !== 1'b0 || d_ack !== 1'b0) begin
            bad++; $display("FAIL mid_abandon got req=%b ack=%b want 0/0", mem_req, d_ack);
        end
        reset = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (mem_req || d_ack || i_ack) busy_seen++;
        end
        total++;
        if (busy_seen !== 0 || order_q.size() !== 0) begin
            bad++; $display("FAIL mid_quiet got busy=%0d acks=%0d want 0/0", busy_seen, order_q.size());
        end
        mem_wait = 2; mem_line = {16{8'h77}};
        i_addr = 32'h300; i_left = 1;
        wait_idle(50, "mid_i");
        total++;
        if (i_rdata !== {16{8'h77}} || rec_addr !== 32'h300 || order_q.size() !== 1) begin
            bad++; $display("FAIL mid_i_after got rdata=%h addr=%h acks=%0d want 77../300/1",
                            i_rdata, rec_addr, order_q.size());
        end
    endtask

    task automatic test_stream();
        string exp;
`ifdef ARB_ROUND_ROBIN_EN
        exp = "DIDIDD";
`else
        exp = "DDDDII";
`endif
        do_reset();
        mem_wait = 1; mem_line = {16{8'h19}};
        @(negedge clk);
        d_addr = 32'h1000; i_addr = 32'h2000; d_left = 4; i_left = 2;
        wait_idle(200, "stream");
        total++;
        if (order_q.size() !== exp.len()) begin
            bad++; $display("FAIL stream_count got=%0d want=%0d", order_q.size(), exp.len());
        end else begin
            for (int k = 0; k < exp.len(); k++) begin
                total++;
                if (order_q[k] !== exp[k]) begin
                    bad++; $display("FAIL stream_order[%0d] got=%c want=%c", k, order_q[k], exp[k]);
                end
            end
        end
        total++;
        if (dbl !== 0 || unstable !== 0 || txn !== 6) begin
            bad++; $display("FAIL stream_proto got dbl=%0d unst=%0d txn=%0d want 0/0/6", dbl, unstable, txn);
        end
    endtask

    initial begin
        test_reset();
        test_i_read();
        test_d_writeback();
        test_tie();
        test_zero_wait();
        test_reset_mid_op();
        test_stream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
